// File: rtl/pulse_stretch.sv
// pulse_stretch: turns one-cycle trigger pulses into fixed-width output pulses
// with a guaranteed idle gap between pulses and a small queue of pending triggers.
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   rst_ni     asynchronous active-low reset
//   trig_i     trigger request, one request per high cycle
//   abort_i    synchronous cancel, wins over trig_i in the same cycle
//   signal_o   stretched pulse (active level = POLARITY), registered
//   busy_o     high whenever the FSM is not idle, registered
//   done_o     one-cycle pulse after each completed active phase, registered
//   drop_o     one-cycle pulse when a trigger is lost to a full queue, registered
//   pending_o  number of queued triggers, registered
module pulse_stretch #(
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned QUEUE_DEPTH = 3,
  parameter bit          POLARITY    = 1'b1,
  localparam int unsigned PW = ($clog2(QUEUE_DEPTH + 1) > 1) ? $clog2(QUEUE_DEPTH + 1) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          trig_i,
  input  logic          abort_i,
  output logic          signal_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          drop_o,
  output logic [PW-1:0] pending_o
);

  localparam int unsigned MAXC     = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int unsigned CW       = ($clog2(MAXC) > 1) ? $clog2(MAXC) : 1;
  localparam int unsigned HI_LOAD  = HIGH_CYCLES - 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam bit          HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            signal_q, signal_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            drop_q, drop_d;

  logic            expired;
  logic            pend_full;
  logic            has_pend;
  logic            exit_now;

  assign expired   = (cnt_q == '0);
  assign pend_full = (pend_q == PW'(QUEUE_DEPTH));
  assign has_pend  = (pend_q != '0);
  // End of the post-pulse idle period: last GAP cycle, or last ACTIVE cycle when there is no gap.
  assign exit_now  = expired && ((state_q == S_GAP) || ((state_q == S_ACTIVE) && !HAS_GAP));

  // Next-state, counter, queue and output-pulse logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;

    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pend_d  = '0;
    end else begin
      done_d = (state_q == S_ACTIVE) && expired;
      if (state_q == S_IDLE) begin
        if (trig_i) begin
          state_d = S_ACTIVE;
          cnt_d   = CW'(HI_LOAD);
        end
      end else if (exit_now) begin
        if (has_pend) begin
          // A trigger arriving as an entry is consumed leaves the count unchanged.
          state_d = S_ACTIVE;
          cnt_d   = CW'(HI_LOAD);
          pend_d  = trig_i ? pend_q : pend_q - PW'(1);
        end else if (trig_i) begin
          // Trigger on the return-to-idle cycle restarts directly without queueing.
          state_d = S_ACTIVE;
          cnt_d   = CW'(HI_LOAD);
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end else begin
        if (trig_i) begin
          if (pend_full) drop_d = 1'b1;
          else           pend_d = pend_q + PW'(1);
        end
        if (expired) begin
          state_d = S_GAP;
          cnt_d   = CW'(GAP_LOAD);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    end

    signal_d = (state_d == S_ACTIVE) ? POLARITY : ~POLARITY;
    busy_d   = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pend_q   <= '0;
      signal_q <= ~POLARITY;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  assign signal_o  = signal_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign drop_o    = drop_q;
  assign pending_o = pend_q;

endmodule
